// File: rtl/uc_pkg.sv
// Shared definitions for the microsequencer: register codes, state encoding,
// ALU operation codes and instruction opcode constants.
package uc_pkg;

   // Write-select / bus-select register codes
   localparam logic [3:0] REG_R0    = 4'd0;
   localparam logic [3:0] REG_PC    = 4'd8;
   localparam logic [3:0] REG_TEMP0 = 4'd9;
   localparam logic [3:0] REG_TEMP1 = 4'd10;
   localparam logic [3:0] REG_TEMP2 = 4'd11;
   localparam logic [3:0] REG_TEMP3 = 4'd12;
   localparam logic [3:0] REG_IR    = 4'd13;
   localparam logic [3:0] REG_NONE  = 4'd15;

   // ALU operation codes
   localparam logic [5:0] ALU_ADD    = 6'h00;
   localparam logic [5:0] ALU_PASS_A = 6'h3C;
   localparam logic [5:0] ALU_INC4   = 6'h3D;
   localparam logic [5:0] ALU_SEXT13 = 6'h3E;

   // Instruction opcode fields
   localparam logic [1:0] OP_ALU = 2'b10;
   localparam logic [1:0] OP_MEM = 2'b11;
   localparam logic [5:0] OP3_LD = 6'h00;

   typedef enum logic [3:0] {
      S_IDLE   = 4'd0,
      S_FETCH  = 4'd1,
      S_PC_INC = 4'd2,
      S_DECODE = 4'd3,
      S_IMM    = 4'd4,
      S_EXEC   = 4'd5,
      S_ADDR   = 4'd6,
      S_MEMRD  = 4'd7,
      S_HALT   = 4'd8
   } state_t;

   // Only r0..r7 are addressable from an instruction register field
   function automatic logic field_ok(input logic [4:0] f);
      return f[4:3] == 2'b00;
   endfunction

   // Map a register field onto a bus/write-select code
   function automatic logic [3:0] reg_code(input logic [4:0] f);
      return {1'b0, f[2:0]};
   endfunction

endpackage

// File: rtl/uc_mem_wait_timer.sv
// Memory wait timer: counts consecutive request cycles without an
// acknowledge and flags expiry on the last allowed cycle.
module uc_mem_wait_timer #(
   parameter int MEM_TIMEOUT = 255
) (
   input  logic clk,
   input  logic rst,
   input  logic active,
   input  logic ack,
   output logic expired
);

   logic [7:0] count;

   // Count un-acked wait cycles; any cycle outside a wait state resets to zero,
   // so every entry into FETCH/MEMRD starts from a clean count
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (!active || ack) begin
         count <= '0;
      end else begin
         count <= count + 8'd1;
      end
   end

   assign expired = active && !ack && (count == 8'(MEM_TIMEOUT - 1));

endmodule

// File: rtl/uc_microsequencer.sv
// Fetch/decode/execute controller for the scratchpad register datapath.
// Outputs are decoded from the state register and the IR fields; memory
// read handshakes are guarded by a wait timer that halts the sequencer.
module uc_microsequencer
   import uc_pkg::*;
#(
   parameter int DATAWIDTH_DECODER_SELECTION = 4,
   parameter int DATAWIDTH_MUX_SELECTION     = 4,
   parameter int DATAWIDTH_ALU_OP            = 6,
   parameter int MEM_TIMEOUT                 = 255
) (
   input  logic                                   uDataPath_CLOCK_50,
   input  logic                                   uDATAPATH_RESET_InHigh,
   input  logic                                   run,
   input  logic                                   mem_ack,
   input  logic [7:0]                             Scratchpath_Reg_IR_OP,
   input  logic [4:0]                             Scratchpath_Reg_IR_RS1,
   input  logic [4:0]                             Scratchpath_Reg_IR_RS2,
   input  logic [4:0]                             Scratchpath_Reg_IR_RD,
   input  logic                                   Scratchpath_Reg_IR_IR13,
   output logic [DATAWIDTH_DECODER_SELECTION-1:0] Selector_Decoder_Wire,
   output logic [DATAWIDTH_MUX_SELECTION-1:0]     Selector_MUX_A_Wire,
   output logic [DATAWIDTH_MUX_SELECTION-1:0]     Selector_MUX_B_Wire,
   output logic [DATAWIDTH_ALU_OP-1:0]            alu_op,
   output logic                                   muxc_sel,
   output logic                                   mem_rd_req,
   output logic                                   instr_done,
   output logic                                   illegal,
   output logic                                   halted,
   output logic [3:0]                             state
);

   state_t     state_q;
   logic       is_alu;
   logic       is_ld;
   logic       legal;
   logic       waiting;
   logic       expired;
   logic [3:0] rd_code;
   logic [3:0] b_code;

   assign is_alu  = Scratchpath_Reg_IR_OP[7:6] == OP_ALU;
   assign is_ld   = Scratchpath_Reg_IR_OP == {OP_MEM, OP3_LD};
   assign legal   = (is_alu || is_ld) && field_ok(Scratchpath_Reg_IR_RS1) &&
                    field_ok(Scratchpath_Reg_IR_RS2) && field_ok(Scratchpath_Reg_IR_RD);
   // Writes to r0 are suppressed
   assign rd_code = (Scratchpath_Reg_IR_RD[2:0] == 3'd0) ? REG_NONE : reg_code(Scratchpath_Reg_IR_RD);
   assign b_code  = Scratchpath_Reg_IR_IR13 ? REG_TEMP0 : reg_code(Scratchpath_Reg_IR_RS2);
   assign waiting = (state_q == S_FETCH) || (state_q == S_MEMRD);
   assign state   = state_q;

   uc_mem_wait_timer #(
      .MEM_TIMEOUT(MEM_TIMEOUT)
   ) u_wait_timer (
      .clk     (uDataPath_CLOCK_50),
      .rst     (uDATAPATH_RESET_InHigh),
      .active  (waiting),
      .ack     (mem_ack),
      .expired (expired)
   );

   // Sequencer state and sticky halt flag
   always_ff @(posedge uDataPath_CLOCK_50 or posedge uDATAPATH_RESET_InHigh) begin
      if (uDATAPATH_RESET_InHigh) begin
         state_q <= S_IDLE;
         halted  <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE:   if (run) state_q <= S_FETCH;
            S_FETCH: begin
               if (expired) begin
                  state_q <= S_HALT;
                  halted  <= 1'b1;
               end else if (mem_ack) begin
                  state_q <= S_PC_INC;
               end
            end
            S_PC_INC: state_q <= S_DECODE;
            S_DECODE: begin
               if (!legal)                       state_q <= S_IDLE;
               else if (Scratchpath_Reg_IR_IR13) state_q <= S_IMM;
               else if (is_alu)                  state_q <= S_EXEC;
               else                              state_q <= S_ADDR;
            end
            S_IMM:    state_q <= is_alu ? S_EXEC : S_ADDR;
            S_EXEC:   state_q <= S_IDLE;
            S_ADDR:   state_q <= S_MEMRD;
            S_MEMRD: begin
               if (expired) begin
                  state_q <= S_HALT;
                  halted  <= 1'b1;
               end else if (mem_ack) begin
                  state_q <= S_IDLE;
               end
            end
            S_HALT:   state_q <= S_HALT;
            default:  state_q <= S_IDLE;
         endcase
      end
   end

   // Datapath control decode from the current state and IR fields
   always_comb begin
      Selector_Decoder_Wire = REG_NONE;
      Selector_MUX_A_Wire   = REG_R0;
      Selector_MUX_B_Wire   = REG_R0;
      alu_op                = ALU_PASS_A;
      muxc_sel              = 1'b0;
      mem_rd_req            = 1'b0;
      instr_done            = 1'b0;
      illegal               = 1'b0;
      case (state_q)
         S_FETCH: begin
            Selector_MUX_A_Wire = REG_PC;
            mem_rd_req          = 1'b1;
            muxc_sel            = 1'b1;
            if (mem_ack) Selector_Decoder_Wire = REG_IR;
         end
         S_PC_INC: begin
            Selector_MUX_A_Wire   = REG_PC;
            alu_op                = ALU_INC4;
            Selector_Decoder_Wire = REG_PC;
         end
         S_DECODE: illegal = !legal;
         S_IMM: begin
            Selector_MUX_A_Wire   = REG_IR;
            alu_op                = ALU_SEXT13;
            Selector_Decoder_Wire = REG_TEMP0;
         end
         S_EXEC: begin
            Selector_MUX_A_Wire   = reg_code(Scratchpath_Reg_IR_RS1);
            Selector_MUX_B_Wire   = b_code;
            alu_op                = Scratchpath_Reg_IR_OP[5:0];
            Selector_Decoder_Wire = rd_code;
            instr_done            = 1'b1;
         end
         S_ADDR: begin
            Selector_MUX_A_Wire   = reg_code(Scratchpath_Reg_IR_RS1);
            Selector_MUX_B_Wire   = b_code;
            alu_op                = ALU_ADD;
            Selector_Decoder_Wire = REG_TEMP1;
         end
         S_MEMRD: begin
            Selector_MUX_A_Wire = REG_TEMP1;
            mem_rd_req          = 1'b1;
            muxc_sel            = 1'b1;
            if (mem_ack) begin
               Selector_Decoder_Wire = rd_code;
               instr_done            = 1'b1;
            end
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_uc_microsequencer.sv
// Bench for uc_microsequencer: an instruction-level model expands each
// instruction into its expected per-cycle control outputs, a compare process
// checks them every cycle, and literal expectations pin the key sequences.
module tb_uc_microsequencer;
   import uc_pkg::*;

   localparam int TO = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic       run;
   logic       mem_ack;
   logic [7:0] ir_op;
   logic [4:0] rs1, rs2, rd;
   logic       ir13;
   logic [3:0] dec, mux_a, mux_b;
   logic [5:0] alu;
   logic       muxc, req, done, ill, halted;
   logic [3:0] st;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [3:0] dec;
      logic [3:0] a;
      logic [3:0] b;
      logic [5:0] alu;
      logic       muxc;
      logic       req;
      logic       done;
      logic       ill;
      logic       halted;
   } obs_t;

   obs_t  exp_cur;
   obs_t  act;
   logic  exp_valid = 1'b0;
   logic  log_en = 1'b0;
   string tag = "";
   int    dec_q[$];
   int    a_q[$];
   int    req_q[$];
   int    done_q[$];
   int    ill_q[$];

   assign act = {dec, mux_a, mux_b, alu, muxc, req, done, ill, halted};

   uc_microsequencer #(
      .DATAWIDTH_DECODER_SELECTION(4),
      .DATAWIDTH_MUX_SELECTION    (4),
      .DATAWIDTH_ALU_OP           (6),
      .MEM_TIMEOUT                (TO)
   ) dut (
      .uDataPath_CLOCK_50     (clk),
      .uDATAPATH_RESET_InHigh (rst),
      .run                    (run),
      .mem_ack                (mem_ack),
      .Scratchpath_Reg_IR_OP  (ir_op),
      .Scratchpath_Reg_IR_RS1 (rs1),
      .Scratchpath_Reg_IR_RS2 (rs2),
      .Scratchpath_Reg_IR_RD  (rd),
      .Scratchpath_Reg_IR_IR13(ir13),
      .Selector_Decoder_Wire  (dec),
      .Selector_MUX_A_Wire    (mux_a),
      .Selector_MUX_B_Wire    (mux_b),
      .alu_op                 (alu),
      .muxc_sel               (muxc),
      .mem_rd_req             (req),
      .instr_done             (done),
      .illegal                (ill),
      .halted                 (halted),
      .state                  (st)
   );

   always #5 clk = ~clk;

   // Per-cycle comparison against the model, away from the active edge
   always @(negedge clk) begin
      if (exp_valid) begin
         checks++;
         if (act !== exp_cur) begin
            errors++;
            $display("FAIL %s cycle: got dec=%h a=%h b=%h alu=%h c=%b req=%b done=%b ill=%b halt=%b, want dec=%h a=%h b=%h alu=%h c=%b req=%b done=%b ill=%b halt=%b",
                     tag, dec, mux_a, mux_b, alu, muxc, req, done, ill, halted,
                     exp_cur.dec, exp_cur.a, exp_cur.b, exp_cur.alu, exp_cur.muxc,
                     exp_cur.req, exp_cur.done, exp_cur.ill, exp_cur.halted);
         end
      end
      if (log_en) begin
         dec_q.push_back(int'(dec));
         a_q.push_back(int'(mux_a));
         req_q.push_back(int'(req));
         done_q.push_back(int'(done));
         ill_q.push_back(int'(ill));
      end
   end

   function automatic obs_t mk(input logic [3:0] d, input logic [3:0] a, input logic [3:0] b,
                               input logic [5:0] o, input logic c, input logic r,
                               input logic dn, input logic il, input logic h);
      obs_t e;
      e = {d, a, b, o, c, r, dn, il, h};
      return e;
   endfunction

   function automatic obs_t idle_obs(input logic h);
      return mk(4'hF, 4'h0, 4'h0, 6'h3C, 1'b0, 1'b0, 1'b0, 1'b0, h);
   endfunction

   task automatic chk(input string name, input int got, input int want);
      checks++;
      if (got != want) begin
         errors++;
         $display("FAIL %s: got %0d want %0d", name, got, want);
      end
   endtask

   // One clock cycle: present inputs and the expected outputs for it
   task automatic step(input obs_t e, input logic r, input logic ack);
      run       = r;
      mem_ack   = ack;
      exp_cur   = e;
      exp_valid = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic clear_logs();
      dec_q.delete(); a_q.delete(); req_q.delete(); done_q.delete(); ill_q.delete();
   endtask

   // Instruction-level model: fw/mw = wait cycles before ack in fetch / load read
   task automatic do_instr(input string name, input logic [1:0] op, input logic [5:0] op3,
                           input logic [4:0] s1, input logic [4:0] s2, input logic [4:0] d,
                           input logic i13, input int fw, input int mw);
      logic       is_alu, is_ld, ok;
      logic [3:0] rdc, bsel, ac;
      tag    = name;
      ir_op  = {op, op3};
      rs1    = s1;
      rs2    = s2;
      rd     = d;
      ir13   = i13;
      is_alu = (op == 2'b10);
      is_ld  = (op == 2'b11) && (op3 == 6'h00);
      ok     = (is_alu || is_ld) && (s1 < 5'd8) && (s2 < 5'd8) && (d < 5'd8);
      rdc    = (d == 5'd0) ? 4'hF : d[3:0];
      bsel   = i13 ? 4'd9 : s2[3:0];
      ac     = s1[3:0];
      clear_logs();
      step(idle_obs(1'b0), 1'b1, 1'b0);
      log_en = 1'b1;
      for (int i = 0; i < fw; i++) step(mk(4'hF, 4'd8, 4'd0, 6'h3C, 1, 1, 0, 0, 0), 1'b0, 1'b0);
      step(mk(4'd13, 4'd8, 4'd0, 6'h3C, 1, 1, 0, 0, 0), 1'b0, 1'b1);
      step(mk(4'd8, 4'd8, 4'd0, 6'h3D, 0, 0, 0, 0, 0), 1'b0, 1'b0);
      step(mk(4'hF, 4'd0, 4'd0, 6'h3C, 0, 0, 0, !ok, 0), 1'b0, 1'b1);
      if (ok) begin
         if (i13) step(mk(4'd9, 4'd13, 4'd0, 6'h3E, 0, 0, 0, 0, 0), 1'b0, 1'b1);
         if (is_alu) begin
            step(mk(rdc, ac, bsel, op3, 0, 0, 1, 0, 0), 1'b0, 1'b0);
         end else begin
            step(mk(4'd10, ac, bsel, 6'h00, 0, 0, 0, 0, 0), 1'b0, 1'b0);
            for (int i = 0; i < mw; i++) step(mk(4'hF, 4'd10, 4'd0, 6'h3C, 1, 1, 0, 0, 0), 1'b0, 1'b0);
            step(mk(rdc, 4'd10, 4'd0, 6'h3C, 1, 1, 1, 0, 0), 1'b0, 1'b1);
         end
      end
      log_en = 1'b0;
      step(idle_obs(1'b0), 1'b0, 1'b1);
   endtask

   initial begin
      int cnt;
      rst = 1'b1; run = 1'b0; mem_ack = 1'b0;
      ir_op = 8'h00; rs1 = '0; rs2 = '0; rd = '0; ir13 = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_dec", int'(dec), 15);
      chk("reset_req", int'(req), 0);
      chk("reset_alu", int'(alu), 'h3C);
      chk("reset_halted", int'(halted), 0);
      chk("reset_state", int'(st), int'(S_IDLE));
      rst = 1'b0;
      @(posedge clk);
      #1;

      // add r3 = r1 + r2, zero wait
      do_instr("add_rr", 2'b10, 6'h00, 5'd1, 5'd2, 5'd3, 1'b0, 0, 0);
      chk("add_rr_latency", dec_q.size(), 4);
      if (dec_q.size() == 4) begin
         chk("add_rr_dec0", dec_q[0], 13);
         chk("add_rr_dec1", dec_q[1], 8);
         chk("add_rr_dec2", dec_q[2], 15);
         chk("add_rr_dec3", dec_q[3], 3);
         chk("add_rr_done_c4", done_q[3], 1);
      end

      // add r5 = r2 + imm
      do_instr("add_imm", 2'b10, 6'h00, 5'd2, 5'd0, 5'd5, 1'b1, 0, 0);
      chk("add_imm_latency", dec_q.size(), 5);
      if (dec_q.size() == 5) begin
         chk("add_imm_temp0", dec_q[3], 9);
         chk("add_imm_rd", dec_q[4], 5);
      end

      // ld r4, [r1 + imm] with 3 wait cycles on the data read
      do_instr("ld_imm", 2'b11, 6'h00, 5'd1, 5'd0, 5'd4, 1'b1, 0, 3);
      cnt = 0;
      foreach (a_q[i]) if (a_q[i] == 10 && req_q[i] == 1) cnt++;
      chk("ld_imm_req_cycles", cnt, 4);
      chk("ld_imm_len", dec_q.size(), 9);
      if (dec_q.size() == 9) begin
         chk("ld_imm_dec_ack", dec_q[8], 4);
         chk("ld_imm_dec_wait", dec_q[7], 15);
         chk("ld_imm_done", done_q[8], 1);
      end

      // Other directed instructions
      do_instr("ld_rr", 2'b11, 6'h00, 5'd6, 5'd5, 5'd7, 1'b0, 2, 0);
      do_instr("alu_rd0", 2'b10, 6'h04, 5'd7, 5'd6, 5'd0, 1'b0, 1, 0);
      do_instr("alu_or", 2'b10, 6'h02, 5'd3, 5'd4, 5'd6, 1'b0, 0, 0);

      // Illegal opcode and illegal rd field
      do_instr("ill_op", 2'b01, 6'h00, 5'd1, 5'd2, 5'd3, 1'b0, 0, 0);
      cnt = 0;
      foreach (ill_q[i]) cnt += ill_q[i];
      chk("ill_op_pulses", cnt, 1);
      do_instr("ill_rd", 2'b10, 6'h00, 5'd1, 5'd2, 5'd9, 1'b0, 0, 0);
      cnt = 0;
      foreach (ill_q[i]) cnt += ill_q[i];
      chk("ill_rd_pulses", cnt, 1);
      cnt = 0;
      foreach (dec_q[i]) if (i >= 2 && dec_q[i] != 15) cnt++;
      chk("ill_rd_no_write", cnt, 0);

      // Reset in the middle of a fetch handshake
      tag = "rst_fetch";
      step(idle_obs(1'b0), 1'b1, 1'b0);
      exp_valid = 1'b0;
      run = 1'b0;
      mem_ack = 1'b0;
      #1;
      chk("rst_fetch_req_before", int'(req), 1);
      rst = 1'b1;
      #1;
      chk("rst_fetch_req_now", int'(req), 0);
      chk("rst_fetch_dec_now", int'(dec), 15);
      @(posedge clk);
      #1;
      chk("rst_fetch_req_next", int'(req), 0);
      chk("rst_fetch_state", int'(st), int'(S_IDLE));
      rst = 1'b0;
      @(posedge clk);
      #1;

      // Timeout with no ack: halt after TO request cycles, then ignore inputs
      tag = "timeout";
      step(idle_obs(1'b0), 1'b1, 1'b0);
      for (int i = 0; i < TO; i++) step(mk(4'hF, 4'd8, 4'd0, 6'h3C, 1, 1, 0, 0, 0), 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) step(idle_obs(1'b1), 1'b1, 1'b1);
      exp_valid = 1'b0;
      chk("timeout_halted", int'(halted), 1);
      chk("timeout_state", int'(st), int'(S_HALT));
      rst = 1'b1;
      #1;
      chk("timeout_reset_halted", int'(halted), 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      do_instr("after_halt", 2'b10, 6'h00, 5'd1, 5'd2, 5'd3, 1'b0, 0, 0);
      exp_valid = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/uc_microsequencer.md
Name: uc_microsequencer

Overview:
- Fetch/decode/execute controller for the scratchpad register datapath (r0..r7, PC, TEMP0..3, IR).
- Drives the write-select decoder code, bus-A/bus-B mux selects, ALU operation and bus-C source select.
- Runs a single-requester memory read handshake for instruction fetch and ld.
- Sits between the datapath and the memory interface; instruction fields come back from the IR outputs.

Parameters:
DATAWIDTH_DECODER_SELECTION, 4, width of write-select code
DATAWIDTH_MUX_SELECTION, 4, width of bus A/B select codes
DATAWIDTH_ALU_OP, 6, ALU operation code width
MEM_TIMEOUT, 255, max cycles waiting for mem_ack before halt (1..255)

Ports:
uDataPath_CLOCK_50  in  1  clock
uDATAPATH_RESET_InHigh  in  1  asynchronous, active-high reset
run  in  1  1 = start a new instruction at FETCH; 0 = remain in IDLE
mem_ack  in  1  memory data valid on bus C source this cycle
Scratchpath_Reg_IR_OP  in  8  {IR[31:30], IR[24:19]} = {op, op3}
Scratchpath_Reg_IR_RS1  in  5  rs1 field
Scratchpath_Reg_IR_RS2  in  5  rs2 field
Scratchpath_Reg_IR_RD  in  5  rd field
Scratchpath_Reg_IR_IR13  in  1  immediate-form flag
Selector_Decoder_Wire  out  4  write-target code; 4'hF = no write
Selector_MUX_A_Wire  out  4  bus-A source code
Selector_MUX_B_Wire  out  4  bus-B source code
alu_op  out  6  ALU operation
muxc_sel  out  1  bus-C source: 0 = ALU, 1 = memory read data
mem_rd_req  out  1  memory read request; address is bus A
instr_done  out  1  one-cycle pulse at instruction completion
illegal  out  1  one-cycle pulse on an unsupported instruction
halted  out  1  sticky; set on timeout, cleared only by reset
state  out  4  current state encoding, for debug

Behaviour:
- Register codes: 0..7 = r0..r7, 8 = PC, 9..12 = TEMP0..3, 13 = IR, 15 = none.
- Outputs are Moore-decoded from the state register plus IR fields. A write commits on the clock edge that ends the state.
- Reset / IDLE / HALT output values:
  - Decoder = 4'hF; MUX_A = 0; MUX_B = 0.
  - alu_op = PASS_A; muxc_sel = 0; mem_rd_req = 0.
  - Pulses = 0; halted = 0 after reset.
  - The reset state is IDLE.
- States and transitions:
  - IDLE: if run, go to FETCH.
  - FETCH: A = PC, mem_rd_req = 1, muxc_sel = 1.
    - Decoder = IR only in the cycle mem_ack = 1.
    - On ack, go to PC_INC.
  - PC_INC: A = PC, alu_op = INC4, write PC; go to DECODE.
  - DECODE: no write. Classify {op, op3}:
    - op = 2'b10 is ALU; op3 is passed as alu_op.
    - {2'b11, 6'b000000} is ld.
    - Anything else is illegal.
    - Go to IMM if IR13 = 1, to EXEC if ALU with IR13 = 0, to ADDR if ld with IR13 = 0.
    - Illegal: assert illegal for 1 cycle, then go to IDLE with no register write (instr_done not asserted).
  - IMM: A = IR, alu_op = SEXT13, write TEMP0. Go to EXEC for ALU, ADDR for ld.
  - EXEC: A = rs1; B = TEMP0 if IR13 = 1 else rs2; alu_op = op3; write rd. Assert instr_done; go to IDLE.
  - ADDR: A = rs1; B = TEMP0 or rs2; alu_op = ADD; write TEMP1. Go to MEMRD.
  - MEMRD: A = TEMP1, mem_rd_req = 1, muxc_sel = 1. Write rd only in the ack cycle. On ack, assert instr_done and go to IDLE.
- Register field rules:
  - rd = 0 gives decoder 4'hF.
  - rs1, rs2 or rd with bits [4:3] != 0 is illegal, detected in DECODE.
- Memory handshake:
  - mem_rd_req holds high until mem_ack.
  - Ack in the first request cycle is legal: zero wait.
  - mem_ack outside FETCH/MEMRD is ignored.
- Timeout:
  - An 8-bit wait counter clears on entering FETCH/MEMRD and increments each cycle without ack.
  - Reaching MEM_TIMEOUT: go to HALT, halted = 1, mem_rd_req drops the next cycle.
  - HALT is left only by reset.
- run is sampled only in IDLE; dropping it mid-instruction does not abort.
- Minimum instruction latency, IDLE excluded, zero-wait memory:
  - reg-reg ALU: 4 cycles.
  - immediate ALU: 5 cycles.
  - ld imm: 6 cycles.
- Reset mid-handshake immediately drops mem_rd_req and all write selects.

Decomposition:
- Shared package uc_pkg holds:
  - register codes: REG_R0..R7, REG_PC = 8, REG_TEMP0..3 = 9..12, REG_IR = 13, REG_NONE = 15;
  - state encoding;
  - ALU codes: ADD = 6'h00, PASS_A = 6'h3C, INC4 = 6'h3D, SEXT13 = 6'h3E;
  - opcode constants OP_ALU = 2'b10, OP_MEM = 2'b11, OP3_LD = 6'h00.
- One natural sub-module: uc_mem_wait_timer (counter plus expiry flag).

Test Plan:
- Reset during FETCH with mem_rd_req = 1 -> next cycle mem_rd_req = 0, Decoder = 4'hF, state = IDLE.
- run = 1, IR = add r3 = r1 + r2 (op = 10, op3 = 0, IR13 = 0), zero-wait ack -> cycle sequence:
  - Decoder 13, 8, F, 3; EXEC with A = 1, B = 2, alu_op = 0x00;
  - instr_done pulses on cycle 4.
- Immediate add r5 = r2 + imm -> IMM writes TEMP0 (code 9) with SEXT13, then EXEC B = 9, Decoder = 5; 5 cycles total.
- ld r4, [r1 + imm] with mem_ack delayed 3 cycles in MEMRD -> A = 10 and mem_rd_req high for exactly 4 cycles; Decoder = 4 only in the ack cycle; instr_done is then asserted.
- IR op = 2'b01, or rd = 5'd9 -> illegal pulses once, no write code other than F after FETCH/PC_INC, return to IDLE.
- MEM_TIMEOUT = 4, mem_ack never asserted -> halted = 1 after 4 request cycles; later mem_ack and run are ignored until reset.
